touch_button_events: RTL and testbench
======================================

# touch_button_events

Downstream stage of the touch-region hit detector: consumes its per-sample hit flag and turns it into clean button events. It debounces the hit with separate press and release sample counts and emits single-cycle press and release pulses. It also maintains a toggle latch and a press counter, plus an optional long-press pulse. Its outputs drive the menu/control logic of the counter display.

## Interface
Parameters:
- DEB_ON, 3: consecutive qualified hit samples needed to register a press (1..15).
- DEB_OFF, 3: consecutive qualified miss samples needed to register a release (1..15).
- LONG_SMP, 16'd500: qualified samples held before long-press fires (≥1).
- CNT_W, 8: press counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- sample_en  in  1  strobe; hit is valid and sampled only on cycles where sample_en=1.
- hit  in  1  region hit flag from the detector.
- pressed  out  1  debounced button level.
- press_pulse  out  1  one-clk pulse on registered press.
- release_pulse  out  1  one-clk pulse on registered release.
- long_pulse  out  1  one-clk pulse on long press (macro-dependent).
- toggle  out  1  flips on every registered press.
- press_cnt  out  CNT_W  count of registered presses, modulo 2^CNT_W.

## Operation
- FSM states:
  - IDLE: released, no hits being counted.
  - ARM: counting consecutive hits.
  - HELD: pressed.
  - DISARM: pressed, counting consecutive misses.
- deb_cnt is 4-bit and is cleared on every state change.
- All transitions are evaluated only when sample_en=1. With sample_en=0 the state, counters and level outputs hold, and all pulses are 0.
- IDLE:
  - hit=1, DEB_ON=1 -> HELD, registers a press.
  - hit=1, DEB_ON>1 -> ARM, deb_cnt=1.
  - hit=0 -> stays in IDLE.
- ARM:
  - hit=1 increments deb_cnt; on reaching DEB_ON -> HELD, registers a press.
  - hit=0 -> IDLE, no event.
- HELD:
  - hit=0, DEB_OFF=1 -> IDLE, registers a release.
  - hit=0, DEB_OFF>1 -> DISARM, deb_cnt=1.
  - hit=1 -> stays in HELD.
- DISARM:
  - hit=0 increments deb_cnt; on reaching DEB_OFF -> IDLE, registers a release.
  - hit=1 -> HELD with no pulse; the long timer is not cleared.
- Registered press, all updated together:
  - pressed=1.
  - press_pulse=1.
  - toggle inverts.
  - press_cnt+1 (wraps all-ones -> 0).
  - long_smp cleared, long_done cleared.
- Registered release: pressed=0, release_pulse=1.
- Long timer (long_smp, 16-bit, saturating):
  - Increments on every qualified sample while in HELD or DISARM.
  - When it reaches LONG_SMP with long_done=0, long_pulse=1 and long_done=1.
  - Fires at most once per press.
- Reset mid-operation: state returns to IDLE and every output is driven low on the next edge. An in-progress press is discarded without a release_pulse.

## Timing
- Reset values: pressed=0, press_pulse=0, release_pulse=0, long_pulse=0, toggle=0, press_cnt=0, state=IDLE, counters 0.
- Latency: outputs are registered and update on the clk edge after the sample_en cycle that completes the condition, i.e. one-cycle latency.
- Pulses are exactly one clk wide, even if sample_en stays high on consecutive cycles.
- press_pulse and long_pulse can never coincide, because long_smp is cleared on press.
- release_pulse and long_pulse may coincide only if LONG_SMP is reached on the release sample. In that case long_pulse is suppressed and release wins.
- No handshake: the consumer must capture pulses on the cycle they are asserted.

## Configuration
- Macro TOUCH_LONGPRESS_EN.
- Defined: long timer, long_done and long_pulse are implemented as described above.
- Undefined: no long timer logic is built, long_pulse is tied to 0, and LONG_SMP is ignored.

## Structure
- Shared package touch_pkg holds:
  - the state enum (IDLE, ARM, HELD, DISARM);
  - the deb_cnt width constant (4);
  - the long timer width constant (16).
- One sub-module is natural: touch_deb_cnt, a clearable, saturating, enable-gated counter with a terminal-match output. It is instantiated for deb_cnt and for long_smp.

## Test plan
- Press: DEB_ON=3, hit=1 on 3 consecutive strobes -> press_pulse one clk after the 3rd strobe; pressed=1, toggle=1, press_cnt=1.
- Bounce on press: hits 1,1,0,1,1,1 -> exactly one press_pulse, after the 6th strobe; no event at strobe 3.
- Release with bounce: from HELD, misses 0,0,1,0,0,0 -> no pulse on the re-hit; release_pulse after the 6th strobe; pressed=0.
- Long press (macro defined, LONG_SMP=5): hold after press for 5 strobes -> long_pulse once at the 5th; no second pulse while held for 20 strobes. Macro undefined -> long_pulse stays 0.
- Counter wrap, CNT_W=2: 5 clean presses -> press_cnt sequence 1,2,3,0,1; toggle ends at 1.
- Reset mid-press: in ARM with deb_cnt=2, assert reset for 1 clk, then 1 hit -> no press_pulse; all outputs 0 after reset; a fresh 3 hits are needed to press.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types and widths for the touch button event stage.
package touch_pkg;

    localparam int DEB_W  = 4;
    localparam int LONG_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HELD   = 2'd2,
        DISARM = 2'd3
    } touch_state_e;

endpackage

// File: rtl/touch_deb_cnt.sv
// Clearable, saturating, enable-gated counter; reach flags that the next enabled
// sample lands the count on term.
module touch_deb_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         reach
);

    logic [W-1:0] inc;

    assign inc   = (cnt == {W{1'b1}}) ? cnt : cnt + {{(W-1){1'b0}}, 1'b1};
    assign reach = (inc == term);

    // A clear restarts the run; if the same sample also counts, it becomes sample 1.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= en ? {{(W-1){1'b0}}, 1'b1} : '0;
        else if (en)
            cnt <= inc;
    end

endmodule

// File: rtl/touch_button_events.sv
// Debounces the region hit flag into press/release/long-press events, toggle and press count.
// Optional long-press timer is built when TOUCH_LONGPRESS_EN is defined.
module touch_button_events
    import touch_pkg::*;
#(
    parameter int          DEB_ON   = 3,
    parameter int          DEB_OFF  = 3,
    parameter logic [15:0] LONG_SMP = 16'd500,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             hit,
    output logic             pressed,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             toggle,
    output logic [CNT_W-1:0] press_cnt
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ARM    = ARM;
    localparam logic [1:0] S_HELD   = HELD;
    localparam logic [1:0] S_DISARM = DISARM;

    localparam logic [DEB_W-1:0] ON_TERM  = DEB_W'(DEB_ON);
    localparam logic [DEB_W-1:0] OFF_TERM = DEB_W'(DEB_OFF);

    logic [1:0]       state, nxt;
    logic             on_side;
    logic             deb_clr, deb_en, deb_reach;
    logic [DEB_W-1:0] deb_cnt, deb_term;
    logic             do_press, do_release;

    assign on_side  = (state == S_HELD) || (state == S_DISARM);
    assign deb_term = on_side ? OFF_TERM : ON_TERM;

    touch_deb_cnt #(.W(DEB_W)) u_deb (
        .clk   (clk),
        .reset (reset),
        .clr   (deb_clr),
        .en    (deb_en),
        .term  (deb_term),
        .cnt   (deb_cnt),
        .reach (deb_reach)
    );

    // deb_cnt is 0 in IDLE/HELD, so deb_reach there means a debounce count of 1.
    always_comb begin
        nxt        = state;
        deb_clr    = 1'b0;
        deb_en     = 1'b0;
        do_press   = 1'b0;
        do_release = 1'b0;
        if (sample_en) begin
            case (state)
                S_IDLE: if (hit) begin
                    deb_clr = 1'b1;
                    if (deb_reach) begin
                        nxt      = S_HELD;
                        do_press = 1'b1;
                    end else begin
                        nxt    = S_ARM;
                        deb_en = 1'b1;
                    end
                end
                S_ARM: if (hit) begin
                    if (deb_reach) begin
                        nxt      = S_HELD;
                        deb_clr  = 1'b1;
                        do_press = 1'b1;
                    end else begin
                        deb_en = 1'b1;
                    end
                end else begin
                    nxt     = S_IDLE;
                    deb_clr = 1'b1;
                end
                S_HELD: if (!hit) begin
                    deb_clr = 1'b1;
                    if (deb_reach) begin
                        nxt        = S_IDLE;
                        do_release = 1'b1;
                    end else begin
                        nxt    = S_DISARM;
                        deb_en = 1'b1;
                    end
                end
                default: if (!hit) begin
                    if (deb_reach) begin
                        nxt        = S_IDLE;
                        deb_clr    = 1'b1;
                        do_release = 1'b1;
                    end else begin
                        deb_en = 1'b1;
                    end
                end else begin
                    nxt     = S_HELD;
                    deb_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
            press_cnt     <= '0;
        end else begin
            state         <= nxt;
            press_pulse   <= do_press;
            release_pulse <= do_release;
            if (do_press) begin
                pressed   <= 1'b1;
                toggle    <= ~toggle;
                press_cnt <= press_cnt + CNT_W'(1);
            end else if (do_release) begin
                pressed <= 1'b0;
            end
        end
    end

`ifdef TOUCH_LONGPRESS_EN
    logic              long_en, long_reach, long_done;
    logic [LONG_W-1:0] long_smp;
    logic              unused_cnt;

    assign long_en    = sample_en && on_side;
    assign unused_cnt = ^{deb_cnt, long_smp};

    touch_deb_cnt #(.W(LONG_W)) u_long (
        .clk   (clk),
        .reset (reset),
        .clr   (do_press),
        .en    (long_en),
        .term  (LONG_SMP),
        .cnt   (long_smp),
        .reach (long_reach)
    );

    // A release on the same sample takes precedence over the long-press event.
    always_ff @(posedge clk) begin
        if (reset) begin
            long_done  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (do_press) begin
                long_done <= 1'b0;
            end else if (long_en && long_reach && !long_done) begin
                long_done  <= 1'b1;
                long_pulse <= !do_release;
            end
        end
    end
`else
    logic unused_cnt;

    assign unused_cnt = ^{deb_cnt, LONG_SMP};
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_touch_button_events.sv
// Directed vector bench for touch_button_events (DEB 3/3, LONG_SMP=5, CNT_W=2).
module tb_touch_button_events;

`ifdef TOUCH_LONGPRESS_EN
    localparam logic LP_EN = 1'b1;
`else
    localparam logic LP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic       hit = 1'b0;
    logic       pressed, press_pulse, release_pulse, long_pulse, toggle;
    logic [1:0] press_cnt;

    int tests = 0;
    int fails = 0;

    touch_button_events #(
        .DEB_ON   (3),
        .DEB_OFF  (3),
        .LONG_SMP (16'd5),
        .CNT_W    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .hit           (hit),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .toggle        (toggle),
        .press_cnt     (press_cnt)
    );

    always #5 clk = ~clk;

    // expected outputs packed as {pressed, press_pulse, release_pulse, long_pulse, toggle, press_cnt}
    typedef struct {
        logic       rst;
        logic       se;
        logic       hit;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, se, h, p, pp, rp, lp, tg, input logic [1:0] c);
        vec_t v;
        v.rst = r;
        v.se  = se;
        v.hit = h;
        v.exp = {p, pp, rp, lp & LP_EN, tg, c};
        vecs.push_back(v);
    endfunction

    function automatic logic [6:0] outs();
        return {pressed, press_pulse, release_pulse, long_pulse, toggle, press_cnt};
    endfunction

    task automatic step(input logic r, se, h);
        reset     = r;
        sample_en = se;
        hit       = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (p,pp,rp,lp,tog,cnt)", name, act, exp);
        end
    endtask

    initial begin
        // reset, press with a strobe gap, long press, release
        add(1,0,0, 0,0,0,0,0,0);
        add(0,1,1, 0,0,0,0,0,0);
        add(0,1,1, 0,0,0,0,0,0);
        add(0,0,1, 0,0,0,0,0,0);
        add(0,1,1, 1,1,0,0,1,1);
        add(0,1,1, 1,0,0,0,1,1);
        add(0,1,0, 1,0,0,0,1,1);
        add(0,1,1, 1,0,0,0,1,1);
        add(0,1,1, 1,0,0,0,1,1);
        add(0,1,1, 1,0,0,1,1,1);
        for (int i = 0; i < 4; i++) add(0,1,1, 1,0,0,0,1,1);
        add(0,0,1, 1,0,0,0,1,1);
        for (int i = 0; i < 16; i++) add(0,1,1, 1,0,0,0,1,1);
        add(0,1,0, 1,0,0,0,1,1);
        add(0,1,0, 1,0,0,0,1,1);
        add(0,1,0, 0,0,1,0,1,1);
        add(0,1,0, 0,0,0,0,1,1);
        // bounce on press: 1,1,0,1,1,1
        add(0,1,1, 0,0,0,0,1,1);
        add(0,1,1, 0,0,0,0,1,1);
        add(0,1,0, 0,0,0,0,1,1);
        add(0,1,1, 0,0,0,0,1,1);
        add(0,1,1, 0,0,0,0,1,1);
        add(0,1,1, 1,1,0,0,0,2);
        // release with bounce: 0,0,1,0,0,0 (long timer keeps counting through DISARM)
        add(0,1,0, 1,0,0,0,0,2);
        add(0,1,0, 1,0,0,0,0,2);
        add(0,1,1, 1,0,0,0,0,2);
        add(0,1,0, 1,0,0,0,0,2);
        add(0,1,0, 1,0,0,1,0,2);
        add(0,1,0, 0,0,1,0,0,2);
        // release on the sample that reaches LONG_SMP: release wins
        add(0,1,1, 0,0,0,0,0,2);
        add(0,1,1, 0,0,0,0,0,2);
        add(0,1,1, 1,1,0,0,1,3);
        add(0,1,1, 1,0,0,0,1,3);
        add(0,1,1, 1,0,0,0,1,3);
        add(0,1,0, 1,0,0,0,1,3);
        add(0,1,0, 1,0,0,0,1,3);
        add(0,1,0, 0,0,1,0,1,3);
        add(0,1,0, 0,0,0,0,1,3);

        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].se, vecs[i].hit);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // counter wrap: 5 clean presses -> 1,2,3,0,1, toggle ends at 1
        step(1,0,0);
        check("wrap_reset", outs(), 7'b0);
        for (int k = 0; k < 5; k++) begin
            logic [1:0] c;
            logic       tg;
            c  = 2'((k + 1) % 4);
            tg = (k % 2 == 0);
            step(0,1,1);
            step(0,1,1);
            step(0,1,1);
            check($sformatf("wrap_press%0d", k), outs(), {1'b1, 1'b1, 1'b0, 1'b0, tg, c});
            step(0,1,0);
            step(0,1,0);
            step(0,1,0);
            check($sformatf("wrap_rel%0d", k), outs(), {1'b0, 1'b0, 1'b1, 1'b0, tg, c});
        end

        // reset mid-press discards the ARM progress
        step(0,1,1);
        step(0,1,1);
        check("arm_pre_reset", outs(), {5'b00001, 2'd1});
        step(1,1,1);
        check("mid_reset", outs(), 7'b0);
        step(0,1,1);
        check("post_reset_hit1", outs(), 7'b0);
        step(0,1,1);
        check("post_reset_hit2", outs(), 7'b0);
        step(0,1,1);
        check("post_reset_hit3", outs(), {5'b11001, 2'd1});
        step(0,1,1);
        check("post_reset_held", outs(), {5'b10001, 2'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
